// File: rtl/elev_pkg.sv
// Shared definitions for the elevator call register.
// Contents: floor count, floor encoding, FSM state type, and small helper
// functions (floor one-hot decode, pending-bit popcount).
package elev_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0] floor_t;

    localparam floor_t FLOOR_A = 2'd0;
    localparam floor_t FLOOR_B = 2'd1;
    localparam floor_t FLOOR_C = 2'd2;
    localparam floor_t FLOOR_D = 2'd3;

    typedef enum logic {
        IDLE      = 1'b0,
        DOOR_OPEN = 1'b1
    } fsm_t;

    // One-hot mask selecting the bit of a floor
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
        logic [NUM_FLOORS-1:0] one;
        one = NUM_FLOORS'(1);
        floor_onehot = one << f;
    endfunction

    // Number of set bits in a pending vector (0..NUM_FLOORS)
    function automatic logic [2:0] popcount(input logic [NUM_FLOORS-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        popcount = cnt;
    endfunction

endpackage

// File: rtl/elev_btn_debounce.sv
// Synchroniser and debouncer for one raw hall-call button.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   btn    - raw asynchronous, bouncing button
//   press  - one-cycle pulse when the button qualifies as pressed
// The synchronised level must be high for DEBOUNCE_CYCLES consecutive
// samples; press fires once per qualified press, however long it is held.
module elev_btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   deb_q_r;
    logic                   deb_s;

    assign deb_s = (cnt_r == DEB_MAX);
    assign press = deb_s & ~deb_q_r;

    // Multi-flop synchroniser for the asynchronous button
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
        end
    end

    // Saturating run-length counter of synchronised high samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (sync_r[SYNC_STAGES-1]) begin
            if (cnt_r != DEB_MAX) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    // Delayed debounced level for rising-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_q_r <= 1'b0;
        end else begin
            deb_q_r <= deb_s;
        end
    end

endmodule

// File: rtl/elev_call_register.sv
// Elevator hall-call register: debounces the hall buttons, latches presses as
// pending calls and serves them with a door-dwell timer.
// Ports:
//   clock       - system clock, rising edge
//   reset       - asynchronous active-low reset
//   btn         - raw hall buttons, bit i = floor i
//   floor       - current car floor (0=A..3=D)
//   call        - pending calls (zero while the door is open)
//   door_open   - high while dwelling at a served floor
//   served      - one-cycle pulse on entry to the door-open state
//   pending_cnt - number of pending calls, one cycle behind pending
// Build option: define ELEV_CALL_CANCEL_EN to let a fresh press of an
// already-pending button cancel that call.
module elev_call_register
    import elev_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DOOR_CYCLES     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  floor_t                floor,
    output logic [NUM_FLOORS-1:0] call,
    output logic                  door_open,
    output logic                  served,
    output logic [2:0]            pending_cnt
);

    localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(DOOR_CYCLES - 1);

    logic [NUM_FLOORS-1:0] press_s;
    logic [NUM_FLOORS-1:0] accept_s;
    logic [NUM_FLOORS-1:0] pend_n_s;
    logic [NUM_FLOORS-1:0] pending_r;
    logic [NUM_FLOORS-1:0] call_r;
    logic [2:0]            pending_cnt_r;
    logic [TW-1:0]         timer_r;
    floor_t                floor_q_r;
    floor_t                srv_floor_r;
    fsm_t                  state_r;
    logic                  door_r;
    logic                  served_r;
    logic                  serve_s;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
        elev_btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .btn   (btn[g]),
            .press (press_s[g])
        );
    end

    // A floor is only served once floor has matched its registered copy
    assign serve_s = (state_r == IDLE) && (floor == floor_q_r) && pending_r[floor];

    // Next pending vector: accept presses, then apply the serve clear (clear wins)
    always_comb begin
        accept_s = press_s;
        if (state_r == DOOR_OPEN) begin
            // a press of the floor being dwelt at is already satisfied
            accept_s = press_s & ~floor_onehot(srv_floor_r);
        end else begin
            accept_s = press_s;
        end
`ifdef ELEV_CALL_CANCEL_EN
        pend_n_s = pending_r ^ accept_s;
`else
        pend_n_s = pending_r | accept_s;
`endif
        if (serve_s) begin
            pend_n_s = pend_n_s & ~floor_onehot(floor);
        end else begin
            pend_n_s = pend_n_s;
        end
    end

    // Pending-call register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r <= {NUM_FLOORS{1'b0}};
        end else begin
            pending_r <= pend_n_s;
        end
    end

    // Registered floor copy and pending popcount
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            floor_q_r     <= FLOOR_A;
            pending_cnt_r <= 3'd0;
        end else begin
            floor_q_r     <= floor;
            pending_cnt_r <= popcount(pending_r);
        end
    end

    // Serve FSM with dwell timer and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            timer_r     <= {TW{1'b0}};
            srv_floor_r <= FLOOR_A;
            door_r      <= 1'b0;
            served_r    <= 1'b0;
            call_r      <= {NUM_FLOORS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (serve_s) begin
                        state_r     <= DOOR_OPEN;
                        timer_r     <= TIMER_LOAD;
                        srv_floor_r <= floor;
                        door_r      <= 1'b1;
                        served_r    <= 1'b1;
                        call_r      <= {NUM_FLOORS{1'b0}};
                    end else begin
                        door_r   <= 1'b0;
                        served_r <= 1'b0;
                        call_r   <= pend_n_s;
                    end
                end
                DOOR_OPEN: begin
                    served_r <= 1'b0;
                    if (timer_r == {TW{1'b0}}) begin
                        state_r <= IDLE;
                        door_r  <= 1'b0;
                        call_r  <= pend_n_s;
                    end else begin
                        timer_r <= timer_r - TW'(1);
                        call_r  <= {NUM_FLOORS{1'b0}};
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    door_r   <= 1'b0;
                    served_r <= 1'b0;
                    call_r   <= {NUM_FLOORS{1'b0}};
                end
            endcase
        end
    end

    assign call        = call_r;
    assign door_open   = door_r;
    assign served      = served_r;
    assign pending_cnt = pending_cnt_r;

endmodule

// File: tb/tb_elev_call_register.sv
// Self-checking bench for elev_call_register: directed scenarios plus random
// button/floor traffic, compared every cycle against a behavioural model
// built on raw-sample run lengths, a pending bit set and a dwell countdown.
module tb_elev_call_register;

    localparam int DEB  = 4;
    localparam int DOOR = 8;

    logic       clock;
    logic       reset;
    logic [3:0] btn;
    logic [1:0] floor;
    logic [3:0] call;
    logic       door_open;
    logic       served;
    logic [2:0] pending_cnt;

    int n_checks;
    int n_fail;

    // reference model state
    int       r_hist [4][4];
    bit [3:0] m_pend;
    bit [3:0] m_call;
    bit       m_door;
    bit       m_served;
    int       m_rem;
    int       m_sf;
    bit [1:0] m_fq;
    int       m_cnt;

    elev_call_register dut (
        .clock       (clock),
        .reset       (reset),
        .btn         (btn),
        .floor       (floor),
        .call        (call),
        .door_open   (door_open),
        .served      (served),
        .pending_cnt (pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) r_hist[i][k] = 0;
        m_pend = 4'b0; m_call = 4'b0; m_door = 1'b0; m_served = 1'b0;
        m_rem = 0; m_sf = 0; m_fq = 2'd0; m_cnt = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge
    task automatic model_step(input logic [3:0] b, input logic [1:0] f);
        bit [3:0] ev;
        bit [3:0] old;
        bit [3:0] acc;
        int nr;
        for (int i = 0; i < 4; i++) begin
            nr = b[i] ? ((r_hist[i][0] < 1000) ? r_hist[i][0] + 1 : 1000) : 0;
            for (int k = 3; k > 0; k--) r_hist[i][k] = r_hist[i][k-1];
            r_hist[i][0] = nr;
            // a qualified press lands 3 edges after its DEB-th raw high sample
            ev[i] = (r_hist[i][3] == DEB);
        end
        old   = m_pend;
        m_cnt = $countones(old);
        acc   = ev;
        if (m_door) acc[m_sf] = 1'b0;
`ifdef ELEV_CALL_CANCEL_EN
        m_pend = old ^ acc;
`else
        m_pend = old | acc;
`endif
        if (m_door) begin
            m_served = 1'b0;
            m_rem--;
            if (m_rem == 0) m_door = 1'b0;
        end else if (f == m_fq && old[f]) begin
            m_pend[f] = 1'b0;
            m_door    = 1'b1;
            m_rem     = DOOR;
            m_sf      = f;
            m_served  = 1'b1;
        end else begin
            m_served = 1'b0;
        end
        m_fq   = f;
        m_call = m_door ? 4'b0 : m_pend;
    endtask

    task automatic compare_all();
        check_val("call", 32'(call), 32'(m_call));
        check_val("door_open", 32'(door_open), 32'(m_door));
        check_val("served", 32'(served), 32'(m_served));
        check_val("pending_cnt", 32'(pending_cnt), 32'(m_cnt));
    endtask

    // Drive inputs, take one rising edge, then compare on the falling edge
    task automatic step(input logic [3:0] b, input logic [1:0] f);
        btn   = b;
        floor = f;
        @(posedge clock);
        if (reset) model_step(b, f);
        @(negedge clock);
        compare_all();
    endtask

    // Asynchronous reset applied between edges, released on a falling edge
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_door", 32'(door_open), 32'd0);
        check_val("async_rst_call", 32'(call), 32'd0);
        check_val("async_rst_cnt", 32'(pending_cnt), 32'd0);
        @(negedge clock);
        step(btn, floor);
        step(btn, floor);
        reset = 1'b1;
    endtask

    initial begin
        int dcnt;
        logic [3:0] rb;
        logic [1:0] rf;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        btn   = 4'b1111;
        floor = 2'd0;
        model_reset();
        @(negedge clock);

        // reset state with all buttons held
        for (int i = 0; i < 3; i++) step(4'b1111, 2'd0);
        check_val("reset_call", 32'(call), 32'd0);
        check_val("reset_door", 32'(door_open), 32'd0);
        check_val("reset_cnt", 32'(pending_cnt), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step(4'b1111, 2'd0);
        check_val("latency_pre", 32'(call), 32'd0);
        step(4'b1111, 2'd0);
        check_val("latency_calls", 32'(call & 4'b1110), 32'(4'b1110));
        for (int i = 0; i < 12; i++) step(4'b1111, 2'd0);

        // bounce on button C: one set, 6 edges after first steady-1 sample
        apply_reset();
        begin
            logic [4:0] pat;
            pat = 5'b01101;
            for (int i = 0; i < 5; i++) step({1'b0, pat[i], 2'b00}, 2'd0);
        end
        for (int i = 0; i < 6; i++) step(4'b0100, 2'd0);
        check_val("bounce_pre", 32'(call), 32'd0);
        step(4'b0100, 2'd0);
        check_val("bounce_call", 32'(call), 32'(4'b0100));
        for (int i = 0; i < 6; i++) step(4'b0100, 2'd0);
        check_val("bounce_cnt", 32'(pending_cnt), 32'd1);

        // serve floor D after the car moves C -> D
        apply_reset();
        for (int i = 0; i < 7; i++) step(4'b1000, 2'd2);
        step(4'b0000, 2'd2);
        step(4'b0000, 2'd2);
        check_val("serve_call_pre", 32'(call), 32'(4'b1000));
        check_val("serve_cnt_pre", 32'(pending_cnt), 32'd1);
        step(4'b0000, 2'd3);
        check_val("serve_not_yet", 32'(served), 32'd0);
        step(4'b0000, 2'd3);
        check_val("serve_pulse", 32'(served), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (door_open) begin
                dcnt++;
                check_val("dwell_call_zero", 32'(call), 32'd0);
            end
            step(4'b0000, (i == 3) ? 2'd1 : 2'd3);
        end
        check_val("dwell_len", 32'(dcnt), 32'(DOOR));
        check_val("serve_cnt_post", 32'(pending_cnt), 32'd0);

        // same-floor press during dwell at B is discarded, D is kept
        apply_reset();
        for (int i = 0; i < 7; i++) step(4'b0010, 2'd1);
        step(4'b0000, 2'd1);
        check_val("b_door", 32'(door_open), 32'd1);
        for (int i = 0; i < 8; i++) step(4'b1010, 2'd1);
        step(4'b0000, 2'd1);
        step(4'b0000, 2'd1);
        check_val("b_after_call", 32'(call), 32'(4'b1000));
        check_val("b_after_door", 32'(door_open), 32'd0);

        // async reset at dwell cycle 4 loses the dwell and other calls
        apply_reset();
        for (int i = 0; i < 7; i++) step(4'b0101, 2'd0);
        step(4'b0000, 2'd0);
        for (int i = 0; i < 3; i++) step(4'b0000, 2'd0);
        check_val("mid_dwell_door", 32'(door_open), 32'd1);
        apply_reset();
        step(4'b0000, 2'd0);
        check_val("lost_calls", 32'(call), 32'd0);

        // press C, release, press C again
        apply_reset();
        for (int i = 0; i < 7; i++) step(4'b0100, 2'd0);
        check_val("cancel_set", 32'(call[2]), 32'd1);
        for (int i = 0; i < 4; i++) step(4'b0000, 2'd0);
        for (int i = 0; i < 7; i++) step(4'b0100, 2'd0);
        for (int i = 0; i < 3; i++) step(4'b0000, 2'd0);
`ifdef ELEV_CALL_CANCEL_EN
        check_val("cancel_clear", 32'(call[2]), 32'd0);
`else
        check_val("cancel_hold", 32'(call[2]), 32'd1);
`endif

        // random traffic against the model
        apply_reset();
        rb = 4'b0;
        rf = 2'd0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
            if ($urandom_range(0, 15) == 0) rf = 2'($urandom_range(0, 3));
            if (n == 700) apply_reset();
            step(rb, rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
